// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared types and constants for the unified-memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    localparam int c_MEM_LAT_DEF = 4;
    localparam int c_CNT_W       = 4;
    localparam int c_DATA_W      = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter_if
// Description : Fetch, data and memory-macro signals of the unified-memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_arbiter_if;
    import mem_arb_pkg::*;

    logic                if_req;
    logic [c_DATA_W-1:0] if_addr;
    logic                if_rdy;
    logic [c_DATA_W-1:0] if_instr;
    logic                if_stall;
    logic                d_re;
    logic                d_we;
    logic [c_DATA_W-1:0] d_addr;
    logic [c_DATA_W-1:0] d_wdata;
    logic                d_rdy;
    logic [c_DATA_W-1:0] d_rdata;
    logic                d_stall;
    logic                halt;
    logic                mem_en;
    logic                mem_we;
    logic [c_DATA_W-1:0] mem_addr;
    logic [c_DATA_W-1:0] mem_wdata;
    logic [c_DATA_W-1:0] mem_rdata;
    logic                busy;

    // Arbiter side
    modport slave (
        input  if_req, if_addr, d_re, d_we, d_addr, d_wdata, halt, mem_rdata,
        output if_rdy, if_instr, if_stall, d_rdy, d_rdata, d_stall,
               mem_en, mem_we, mem_addr, mem_wdata, busy
    );

    // Pipeline stages and memory macro side
    modport master (
        output if_req, if_addr, d_re, d_we, d_addr, d_wdata, halt, mem_rdata,
        input  if_rdy, if_instr, if_stall, d_rdy, d_rdata, d_stall,
               mem_en, mem_we, mem_addr, mem_wdata, busy
    );

endinterface
`default_nettype wire

// File: rtl/lat_counter.sv
`default_nettype none
// ============================================================================
// Module      : lat_counter
// Description : Loadable down-counter with zero flag; times the memory access.
// Revision    : 1.0 - initial release
// ============================================================================
module lat_counter #(
    parameter int WIDTH = 4
) (
    input  wire             clk,
    input  wire             rst,
    input  wire             i_load,
    input  wire             i_dec,
    input  wire [WIDTH-1:0] i_load_val,
    output logic            o_zero
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign o_zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Grants the single-ported unified memory to fetch or data stage,
//               holds the access for MEM_LAT cycles and returns a ready pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_LAT = c_MEM_LAT_DEF
) (
    input  wire          clk,
    input  wire          rst,
    mem_arbiter_if.slave bus
);

    localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(MEM_LAT - 1);

    arb_state_t          r_state;
    owner_t              r_owner;
    logic                r_write;
    logic [c_DATA_W-1:0] r_addr;
    logic [c_DATA_W-1:0] r_wdata;
    logic [c_DATA_W-1:0] r_instr;
    logic [c_DATA_W-1:0] r_rdata;
    logic                r_mem_en;
    logic                r_mem_we;
    logic                r_if_rdy;
    logic                r_d_rdy;

    logic                w_d_req;
    logic                w_i_req;
    logic                w_grant;
    logic                w_cnt_dec;
    logic                w_cnt_zero;

    assign w_d_req   = bus.d_re | bus.d_we;
    assign w_i_req   = bus.if_req & ~bus.halt;
    assign w_grant   = (r_state == IDLE) & (w_d_req | w_i_req);
    assign w_cnt_dec = (r_state == ACC) & ~w_cnt_zero;

    lat_counter #(
        .WIDTH (c_CNT_W)
    ) u_lat_counter (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_grant),
        .i_dec      (w_cnt_dec),
        .i_load_val (c_CNT_LOAD),
        .o_zero     (w_cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_owner  <= OWN_I;
            r_write  <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_instr  <= '0;
            r_rdata  <= '0;
            r_mem_en <= 1'b0;
            r_mem_we <= 1'b0;
            r_if_rdy <= 1'b0;
            r_d_rdy  <= 1'b0;
        end else begin
            r_if_rdy <= 1'b0;
            r_d_rdy  <= 1'b0;
            case (r_state)
                IDLE: begin
                    // Data wins; a simultaneous read+write is treated as a write
                    if (w_d_req) begin
                        r_owner  <= OWN_D;
                        r_write  <= bus.d_we;
                        r_addr   <= bus.d_addr;
                        r_wdata  <= bus.d_wdata;
                        r_mem_en <= 1'b1;
                        r_mem_we <= bus.d_we;
                        r_state  <= ACC;
                    end else if (w_i_req) begin
                        r_owner  <= OWN_I;
                        r_write  <= 1'b0;
                        r_addr   <= bus.if_addr;
                        r_mem_en <= 1'b1;
                        r_mem_we <= 1'b0;
                        r_state  <= ACC;
                    end
                end
                ACC: begin
                    if (w_cnt_zero) begin
                        if (r_owner == OWN_I) begin
                            r_instr <= bus.mem_rdata;
                        end else if (!r_write) begin
                            r_rdata <= bus.mem_rdata;
                        end
                        r_if_rdy <= (r_owner == OWN_I);
                        r_d_rdy  <= (r_owner == OWN_D);
                        r_mem_en <= 1'b0;
                        r_mem_we <= 1'b0;
                        r_state  <= DONE;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.if_rdy    = r_if_rdy;
    assign bus.if_instr  = r_instr;
    assign bus.if_stall  = bus.if_req & ~r_if_rdy;
    assign bus.d_rdy     = r_d_rdy;
    assign bus.d_rdata   = r_rdata;
    assign bus.d_stall   = w_d_req & ~r_d_rdy;
    assign bus.mem_en    = r_mem_en;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_addr;
    assign bus.mem_wdata = r_wdata;
    assign bus.busy      = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Cycle-by-cycle vector bench for mem_arbiter with MEM_LAT = 4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    logic clk;
    logic rst;
    mem_arbiter_if bus ();

    mem_arbiter #(
        .MEM_LAT (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        rst, ir;
        logic [15:0] ia;
        logic        dr, dw;
        logic [15:0] da, dd;
        logic        h;
        logic [15:0] mr;
        logic        en, we;
        logic [15:0] ma, md;
        logic        irdy, drdy, bsy;
        logic [15:0] ins, rd;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   row      = -1;

    function automatic vec_t mk(input int r, ir, ia, dr, dw, da, dd, h, mr,
                                input int en, we, ma, md, irdy, drdy, bsy, ins, rd);
        vec_t v;
        v.rst = 1'(r);   v.ir = 1'(ir);   v.ia = 16'(ia);
        v.dr = 1'(dr);   v.dw = 1'(dw);   v.da = 16'(da);  v.dd = 16'(dd);
        v.h = 1'(h);     v.mr = 16'(mr);
        v.en = 1'(en);   v.we = 1'(we);   v.ma = 16'(ma);  v.md = 16'(md);
        v.irdy = 1'(irdy); v.drdy = 1'(drdy); v.bsy = 1'(bsy);
        v.ins = 16'(ins); v.rd = 16'(rd);
        return v;
    endfunction

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s (row %0d): got %b expected %b", name, row, act, exp);
        end
    endtask

    task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s (row %0d): got %h expected %h", name, row, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rst           = v.rst;
        bus.if_req    = v.ir;
        bus.if_addr   = v.ia;
        bus.d_re      = v.dr;
        bus.d_we      = v.dw;
        bus.d_addr    = v.da;
        bus.d_wdata   = v.dd;
        bus.halt      = v.h;
        bus.mem_rdata = v.mr;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Single fetch of 0x0010
        vecs.push_back(mk(0,1,'h0010,0,0,0,0,0,'hDEAD, 0,0,0,0,      0,0,0, 'h0000,'h0000));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(0,1,'h0010,0,0,0,0,0,'hDEAD, 1,0,'h0010,0, 0,0,1, 'h0000,'h0000));
        vecs.push_back(mk(0,1,'h0010,0,0,0,0,0,'hB105, 1,0,'h0010,0, 0,0,1, 'h0000,'h0000));
        vecs.push_back(mk(0,1,'h0010,0,0,0,0,0,'hDEAD, 0,0,0,0,      1,0,1, 'hB105,'h0000));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,'hDEAD,      0,0,0,0,      0,0,0, 'hB105,'h0000));
        // Fetch and load together: load first, fetch afterwards
        vecs.push_back(mk(0,1,'h0020,1,0,'h1000,0,0,'hDEAD, 0,0,0,0,      0,0,0, 'hB105,'h0000));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(0,1,'h0020,1,0,'h1000,0,0,'hDEAD, 1,0,'h1000,0, 0,0,1, 'hB105,'h0000));
        vecs.push_back(mk(0,1,'h0020,1,0,'h1000,0,0,'h5A5A, 1,0,'h1000,0, 0,0,1, 'hB105,'h0000));
        vecs.push_back(mk(0,1,'h0020,1,0,'h1000,0,0,'hDEAD, 0,0,0,0,      0,1,1, 'hB105,'h5A5A));
        vecs.push_back(mk(0,1,'h0020,0,0,0,0,0,'hDEAD,      0,0,0,0,      0,0,0, 'hB105,'h5A5A));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(0,1,'h0020,0,0,0,0,0,'hDEAD, 1,0,'h0020,0, 0,0,1, 'hB105,'h5A5A));
        vecs.push_back(mk(0,1,'h0020,0,0,0,0,0,'hC0DE,      1,0,'h0020,0, 0,0,1, 'hB105,'h5A5A));
        vecs.push_back(mk(0,1,'h0020,0,0,0,0,0,'hDEAD,      0,0,0,0,      1,0,1, 'hC0DE,'h5A5A));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,'hDEAD,           0,0,0,0,      0,0,0, 'hC0DE,'h5A5A));
        // Store 0x1234 to 0x0040, d_rdata must hold
        vecs.push_back(mk(0,0,0,0,1,'h0040,'h1234,0,'hFFFF, 0,0,0,0,            0,0,0, 'hC0DE,'h5A5A));
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(0,0,0,0,1,'h0040,'h1234,0,'hFFFF, 1,1,'h0040,'h1234, 0,0,1, 'hC0DE,'h5A5A));
        vecs.push_back(mk(0,0,0,0,1,'h0040,'h1234,0,'hFFFF, 0,0,0,0,            0,1,1, 'hC0DE,'h5A5A));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,'hFFFF,            0,0,0,0,            0,0,0, 'hC0DE,'h5A5A));
        // Read and write asserted together is a write
        vecs.push_back(mk(0,0,0,1,1,'h0050,'h00AA,0,'hFFFF, 0,0,0,0,            0,0,0, 'hC0DE,'h5A5A));
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(0,0,0,1,1,'h0050,'h00AA,0,'hFFFF, 1,1,'h0050,'h00AA, 0,0,1, 'hC0DE,'h5A5A));
        vecs.push_back(mk(0,0,0,1,1,'h0050,'h00AA,0,'hFFFF, 0,0,0,0,            0,1,1, 'hC0DE,'h5A5A));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,'hFFFF,            0,0,0,0,            0,0,0, 'hC0DE,'h5A5A));
        // halt raised in cycle 2 of a fetch; no new fetch while halted
        vecs.push_back(mk(0,1,'h0030,0,0,0,0,0,'hDEAD, 0,0,0,0,      0,0,0, 'hC0DE,'h5A5A));
        vecs.push_back(mk(0,1,'h0030,0,0,0,0,0,'hDEAD, 1,0,'h0030,0, 0,0,1, 'hC0DE,'h5A5A));
        vecs.push_back(mk(0,1,'h0030,0,0,0,0,1,'hDEAD, 1,0,'h0030,0, 0,0,1, 'hC0DE,'h5A5A));
        vecs.push_back(mk(0,1,'h0030,0,0,0,0,1,'hDEAD, 1,0,'h0030,0, 0,0,1, 'hC0DE,'h5A5A));
        vecs.push_back(mk(0,1,'h0030,0,0,0,0,1,'h7777, 1,0,'h0030,0, 0,0,1, 'hC0DE,'h5A5A));
        vecs.push_back(mk(0,1,'h0030,0,0,0,0,1,'hDEAD, 0,0,0,0,      1,0,1, 'h7777,'h5A5A));
        vecs.push_back(mk(0,1,'h0034,0,0,0,0,1,'hDEAD, 0,0,0,0,      0,0,0, 'h7777,'h5A5A));
        vecs.push_back(mk(0,1,'h0034,0,0,0,0,1,'hDEAD, 0,0,0,0,      0,0,0, 'h7777,'h5A5A));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,'hDEAD,      0,0,0,0,      0,0,0, 'h7777,'h5A5A));
        // Reset in cycle 2 of a load abandons it and clears the data registers
        vecs.push_back(mk(0,0,0,1,0,'h2000,0,0,'hDEAD, 0,0,0,0,      0,0,0, 'h7777,'h5A5A));
        vecs.push_back(mk(0,0,0,1,0,'h2000,0,0,'hDEAD, 1,0,'h2000,0, 0,0,1, 'h7777,'h5A5A));
        vecs.push_back(mk(1,0,0,1,0,'h2000,0,0,'hDEAD, 1,0,'h2000,0, 0,0,1, 'h7777,'h5A5A));
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(0,0,0,0,0,0,0,0,'h3333,  0,0,0,0,      0,0,0, 'h0000,'h0000));
        // Fresh fetch after reset, normal latency
        vecs.push_back(mk(0,1,'h0044,0,0,0,0,0,'hDEAD, 0,0,0,0,      0,0,0, 'h0000,'h0000));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(0,1,'h0044,0,0,0,0,0,'hDEAD, 1,0,'h0044,0, 0,0,1, 'h0000,'h0000));
        vecs.push_back(mk(0,1,'h0044,0,0,0,0,0,'h4444, 1,0,'h0044,0, 0,0,1, 'h0000,'h0000));
        vecs.push_back(mk(0,1,'h0044,0,0,0,0,0,'hDEAD, 0,0,0,0,      1,0,1, 'h4444,'h0000));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,'hDEAD,      0,0,0,0,      0,0,0, 'h4444,'h0000));

        // Reset with every input high
        rst           = 1'b1;
        bus.if_req    = 1'b1;
        bus.if_addr   = 16'hFFFF;
        bus.d_re      = 1'b1;
        bus.d_we      = 1'b1;
        bus.d_addr    = 16'hFFFF;
        bus.d_wdata   = 16'hFFFF;
        bus.halt      = 1'b1;
        bus.mem_rdata = 16'hFFFF;
        repeat (2) @(posedge clk);
        #1;
        chk1 ("rst_if_rdy",    bus.if_rdy,    1'b0);
        chk1 ("rst_d_rdy",     bus.d_rdy,     1'b0);
        chk1 ("rst_mem_en",    bus.mem_en,    1'b0);
        chk1 ("rst_mem_we",    bus.mem_we,    1'b0);
        chk16("rst_mem_addr",  bus.mem_addr,  16'h0000);
        chk16("rst_mem_wdata", bus.mem_wdata, 16'h0000);
        chk16("rst_if_instr",  bus.if_instr,  16'h0000);
        chk16("rst_d_rdata",   bus.d_rdata,   16'h0000);
        chk1 ("rst_busy",      bus.busy,      1'b0);

        foreach (vecs[i]) begin
            row = i;
            drive(vecs[i]);
            @(negedge clk);
            chk1 ("mem_en",   bus.mem_en,   vecs[i].en);
            chk1 ("mem_we",   bus.mem_we,   vecs[i].we);
            if (vecs[i].en)
                chk16("mem_addr", bus.mem_addr, vecs[i].ma);
            if (vecs[i].we)
                chk16("mem_wdata", bus.mem_wdata, vecs[i].md);
            chk1 ("if_rdy",   bus.if_rdy,   vecs[i].irdy);
            chk1 ("d_rdy",    bus.d_rdy,    vecs[i].drdy);
            chk1 ("busy",     bus.busy,     vecs[i].bsy);
            chk16("if_instr", bus.if_instr, vecs[i].ins);
            chk16("d_rdata",  bus.d_rdata,  vecs[i].rd);
            chk1 ("if_stall", bus.if_stall, vecs[i].ir & ~vecs[i].irdy);
            chk1 ("d_stall",  bus.d_stall,  (vecs[i].dr | vecs[i].dw) & ~vecs[i].drdy);
            next_cycle();
        end

        // Fetch held under halt for 20 cycles: memory never enabled
        row         = -2;
        bus.halt    = 1'b1;
        bus.if_req  = 1'b1;
        bus.if_addr = 16'h0060;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk1("halt_mem_en", bus.mem_en, 1'b0);
            chk1("halt_busy",   bus.busy,   1'b0);
            next_cycle();
        end
        bus.halt = 1'b0;
        next_cycle();
        @(negedge clk);
        chk1 ("unhalt_mem_en",   bus.mem_en,   1'b1);
        chk16("unhalt_mem_addr", bus.mem_addr, 16'h0060);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

Sequencing controller for the single-ported, fixed-latency unified memory shared by instruction fetch and the data-memory stage of the 16-bit pipeline. Each cycle it grants the memory to at most one requester and holds address, enable and write data steady for the full access latency. It returns a registered ready pulse with read data, and produces the stall signals the pipeline uses to freeze fetch or the MEM stage. It sits between the fetch/MEM stages (driven by the decoder's MemRead/MemWrite/Halt control bits) and the memory macro.

## Interface
- MEM_LAT, 4: memory access latency in cycles; legal 1..15.
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- if_req  in  1  fetch request (level).
- if_addr  in  16  fetch address (PC).
- if_rdy  out  1  one-cycle pulse: fetch complete.
- if_instr  out  16  fetched instruction, held until next fetch completion.
- if_stall  out  1  if_req & ~if_rdy.
- d_re  in  1  data read request (MemRead).
- d_we  in  1  data write request (MemWrite).
- d_addr  in  16  data address.
- d_wdata  in  16  store data.
- d_rdy  out  1  one-cycle pulse: data access complete (read or write).
- d_rdata  out  16  load data, held until next read completion.
- d_stall  out  1  (d_re|d_we) & ~d_rdy.
- halt  in  1  Halt control bit; blocks new fetch grants.
- mem_en  out  1  memory enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  16  memory address.
- mem_wdata  out  16  memory write data.
- mem_rdata  in  16  memory read data, valid in last access cycle.
- busy  out  1  state != IDLE.

## Operation
- States: IDLE, ACC, DONE.
- IDLE:
  - If d_re|d_we: grant D; latch d_addr, d_wdata and the write flag (write = d_we). If d_re and d_we are both set, the access is a write.
  - Else if if_req & ~halt: grant I; latch if_addr.
  - On either grant, load the counter with MEM_LAT-1 and go to ACC. Otherwise stay in IDLE.
- ACC:
  - mem_en=1. mem_addr and mem_wdata come from the latched values. mem_we = write flag & owner==D.
  - Counter decrements each cycle.
  - At counter==0: capture mem_rdata into if_instr (owner I) or into d_rdata (owner D read), then go to DONE.
- DONE: pulse the owner's rdy, then go to IDLE. No arbitration happens in DONE.
- Request inputs are don't-care after the grant; latched values are used.
- Priority: data always beats fetch. Fetch cannot starve, because a data request is dropped once d_rdy is seen.
- halt: no new fetch grant while halt is high. An in-flight fetch completes normally. Data requests are still served.
- Writes: d_rdy pulses; d_rdata is unchanged.
- Reset, including mid-access: next state is IDLE, and every output is 0 (if_instr, d_rdata, mem_* and rdy included). The abandoned access carries no guarantee about memory contents.

## Timing
- The request is sampled in IDLE at cycle 0.
- mem_en is high in cycles 1..MEM_LAT.
- The rdy pulse and valid data appear in cycle MEM_LAT+1 (DONE).
- The FSM is back in IDLE at MEM_LAT+2, where the next request is sampled.
- Throughput: one access per MEM_LAT+2 cycles.
- Requesters must update req/addr at the edge ending the DONE cycle.
- MEM_LAT=1: ACC lasts exactly one cycle.
- Stall outputs are combinational from registered rdy and the request inputs.

## Structure
- Shared package `mem_arb_pkg`: state enum (IDLE/ACC/DONE), owner encoding (OWN_I=0, OWN_D=1), MEM_LAT default, counter width (4).
- One sub-module, `lat_counter`: loadable 4-bit down-counter with a zero flag.

## Test plan
- Reset with all inputs high → all outputs 0; busy=0; state IDLE.
- MEM_LAT=4, if_req with if_addr=0x0010, mem_rdata=0xB105 in cycle 4 → mem_en high cycles 1–4 with mem_addr=0x0010, mem_we=0; if_rdy in cycle 5; if_instr=0xB105.
- Cycle 0: if_req with if_addr=0x0020 and d_re with d_addr=0x1000 together → D granted first, d_rdy in cycle 5. Fetch granted at cycle 6, mem_en cycles 7–10, if_rdy in cycle 11.
- Store, d_we with d_addr=0x0040 and d_wdata=0x1234 → mem_we=1 and mem_wdata=0x1234 in cycles 1–4; d_rdy in cycle 5; d_rdata unchanged.
- halt=1 with if_req held → no mem_en for 20 cycles. Raising halt during cycle 2 of a fetch → that fetch still completes, with if_rdy in cycle 5.
- rst asserted in cycle 2 of an access → IDLE in cycle 3, mem_en=0, no rdy pulse. A new request after rst drops is served with normal latency.
